apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter m, default 8, data width of every requester payload and of o_data.
REQ-002 Parameter TIMEOUT, default 16, WAIT-state cycle limit; legal range 2..255.
REQ-003 Port PCLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port PRESET  input  1  reset, asynchronous, active-low.
REQ-005 Port req  input  4  per-requester request, bit k = requester k.
REQ-006 Port req_data  input  4*m  payloads, slice [k*m +: m] = requester k.
REQ-007 Port req_sel  input  8  protocol selects, slice [2k +: 2] = requester k.
REQ-008 Port req_chk  input  4  per-requester read/check flag.
REQ-009 Port gnt  output  4  one-hot grant.
REQ-010 Port done  output  4  one-cycle completion pulse, bit k = requester k.
REQ-011 Port err  output  4  one-cycle error/timeout pulse, bit k = requester k.
REQ-012 Port o_data  output  m  payload to APB master i_data.
REQ-013 Port o_data_ready  output  1  write-issue strobe to APB master i_data_ready.
REQ-014 Port o_data_check  output  1  read-issue strobe to APB master i_data_check.
REQ-015 Port o_protocol_sel  output  2  slave select to APB master i_protocol_sel.
REQ-016 Port i_waiting  input  1  APB master idle/ready indication.
REQ-017 Port i_transfer_done  input  1  APB master transfer-complete indication.
REQ-018 Port i_alu_error  input  1  upstream ALU error.
REQ-019 Port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM shall have exactly three states: IDLE, ISSUE, WAIT.
REQ-021 IDLE: when |req = 1, i_waiting = 1 and i_alu_error = 0, the winner k shall be the first asserted req bit searching upward from (last+1) mod 4, wrapping.
REQ-022 On that edge, req_data/req_sel/req_chk slices of k shall be registered into o_data/o_protocol_sel/a chk register, gnt set to one-hot k, and the FSM shall enter ISSUE (grant latency one cycle).
REQ-023 IDLE with i_alu_error = 1 or i_waiting = 0 shall issue no grant and remain in IDLE.
REQ-024 ISSUE lasts exactly one cycle: o_data_check = chk and o_data_ready = ~chk; next state WAIT; timer cleared to 0.
REQ-025 o_data_ready and o_data_check shall be 0 in all states other than ISSUE and never high together.
REQ-026 WAIT: o_data, o_protocol_sel and gnt held stable; timer increments by 1 per cycle.
REQ-027 WAIT with i_alu_error = 1: err[k] pulses one cycle, last = k, next IDLE; error has priority over i_transfer_done in the same cycle.
REQ-028 WAIT with i_transfer_done = 1 and i_alu_error = 0: done[k] pulses one cycle, last = k, next IDLE.
REQ-029 WAIT with timer = TIMEOUT-1 and no done/error: err[k] pulses, last = k, next IDLE.
REQ-030 gnt shall clear on the same edge the FSM returns to IDLE; done/err pulse coincides with the first IDLE cycle.
REQ-031 req[k] deasserted while granted shall be ignored; the transaction completes normally.
REQ-032 A new grant shall not occur earlier than the cycle after done/err (no back-to-back overlap).
REQ-033 Timer shall be width ceil(log2(TIMEOUT)) and never wrap past TIMEOUT-1.

Reset
REQ-034 PRESET = 0 shall asynchronously force state IDLE, last = 3, timer 0, chk 0, and gnt, done, err, o_data, o_data_ready, o_data_check, o_protocol_sel, o_busy all 0.
REQ-035 Reset asserted mid-transaction shall abort without done/err pulses; after release, arbitration restarts with requester 0 highest priority.

Verification
REQ-036 req=4'b1111 held, i_waiting=1, i_transfer_done pulsed 3 cycles after each ISSUE -> gnt sequence 0001,0010,0100,1000,0001; done pulses in same order.
REQ-037 req=4'b0100, req_sel slice=2'b10, req_chk=0, data=8'hA5 -> ISSUE cycle o_data=A5, o_protocol_sel=10, o_data_ready=1, o_data_check=0.
REQ-038 Grant held, no i_transfer_done for 16 cycles (TIMEOUT=16) -> err[k] one cycle after 16th WAIT cycle, gnt=0.
REQ-039 i_alu_error and i_transfer_done both 1 in WAIT -> err[k]=1, done=0; with i_alu_error=1 in IDLE and req=0001 -> gnt stays 0.
REQ-040 PRESET low during WAIT for requester 2 -> all outputs 0 immediately; after release req=0101 -> requester 0 granted first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter feeding four requesters into one APB master
module apb_req_arbiter #(
  parameter int m       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic [3:0]     req,
  input  logic [4*m-1:0] req_data,
  input  logic [7:0]     req_sel,
  input  logic [3:0]     req_chk,
  output logic [3:0]     gnt,
  output logic [3:0]     done,
  output logic [3:0]     err,
  output logic [m-1:0]   o_data,
  output logic           o_data_ready,
  output logic           o_data_check,
  output logic [1:0]     o_protocol_sel,
  input  logic           i_waiting,
  input  logic           i_transfer_done,
  input  logic           i_alu_error,
  output logic           o_busy
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d, win, idx, cur;
  logic [TW-1:0] timer_q, timer_d;
  logic          chk_q, chk_d, rdy_q, rdy_d, chko_q, chko_d, found, finish;
  logic [3:0]    gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [m-1:0]  data_q, data_d;
  logic [1:0]    sel_q, sel_d;
  assign cur    = {gnt_q[3] | gnt_q[2], gnt_q[3] | gnt_q[1]};
  assign finish = i_alu_error || i_transfer_done || timer_q == TLAST;
  // first asserted request searching upward from the slot after the last winner
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  // next-state and registered-output computation for the three-state transaction FSM
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    chk_d   = chk_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    sel_d   = sel_q;
    done_d  = '0;
    err_d   = '0;
    rdy_d   = 1'b0;
    chko_d  = 1'b0;
    unique case (state_q)
      IDLE: if (found && i_waiting && !i_alu_error) begin
        state_d = ISSUE;
        gnt_d   = 4'b0001 << win;
        data_d  = req_data[int'(win)*m +: m];
        sel_d   = req_sel[2*int'(win) +: 2];
        chk_d   = req_chk[win];
        rdy_d   = ~req_chk[win];
        chko_d  = req_chk[win];
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (finish) begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = cur;
        done_d  = (i_transfer_done && !i_alu_error) ? gnt_q : 4'b0;
        err_d   = (i_transfer_done && !i_alu_error) ? 4'b0 : gnt_q;
      end else timer_d = timer_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously by PRESET
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      timer_q <= '0;
      chk_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      rdy_q   <= 1'b0;
      chko_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      chk_q   <= chk_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rdy_q   <= rdy_d;
      chko_q  <= chko_d;
    end
  end
  assign gnt            = gnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign o_data         = data_q;
  assign o_protocol_sel = sel_q;
  assign o_data_ready   = rdy_q;
  assign o_data_check   = chko_q;
  assign o_busy         = state_q != IDLE;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed scenario checks for apb_req_arbiter
module tb_apb_req_arbiter;
  logic        PCLK, PRESET;
  logic [3:0]  req, req_chk, gnt, done, err;
  logic [31:0] req_data;
  logic [7:0]  req_sel, o_data;
  logic        o_data_ready, o_data_check, i_waiting, i_transfer_done, i_alu_error, o_busy;
  logic [1:0]  o_protocol_sel;
  int          checks = 0, errors = 0;
  apb_req_arbiter #(.m(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_data(req_data), .req_sel(req_sel),
    .req_chk(req_chk), .gnt(gnt), .done(done), .err(err), .o_data(o_data),
    .o_data_ready(o_data_ready), .o_data_check(o_data_check), .o_protocol_sel(o_protocol_sel),
    .i_waiting(i_waiting), .i_transfer_done(i_transfer_done), .i_alu_error(i_alu_error),
    .o_busy(o_busy)
  );
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask
  task automatic test_reset();
    PRESET = 1'b0; req = '0; req_data = '0; req_sel = '0; req_chk = '0;
    i_waiting = 1'b1; i_transfer_done = 1'b0; i_alu_error = 1'b0;
    cyc(); cyc();
    checks++; if ({gnt, done, err} !== 12'h0) begin errors++; $display("FAIL reset_gnt_done_err: got %h expected 000", {gnt, done, err}); end
    checks++; if ({o_data, o_protocol_sel, o_data_ready, o_data_check, o_busy} !== 13'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {o_data, o_protocol_sel, o_data_ready, o_data_check, o_busy}); end
    PRESET = 1'b1;
    cyc();
  endtask
  task automatic test_issue();
    req = 4'b0100; req_data = 32'h00A5_0000; req_sel = 8'b00_10_00_00; req_chk = 4'b0000;
    cyc();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL issue_gnt: got %b expected 0100", gnt); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL issue_data: got %h expected a5", o_data); end
    checks++; if (o_protocol_sel !== 2'b10) begin errors++; $display("FAIL issue_sel: got %b expected 10", o_protocol_sel); end
    checks++; if ({o_data_ready, o_data_check, o_busy} !== 3'b101) begin errors++; $display("FAIL issue_strobes: got %b expected 101", {o_data_ready, o_data_check, o_busy}); end
    req = 4'b0000;
    cyc();
    checks++; if ({o_data_ready, o_data_check, gnt, o_data} !== {2'b00, 4'b0100, 8'hA5}) begin errors++; $display("FAIL wait_hold: got %h expected %h", {o_data_ready, o_data_check, gnt, o_data}, {2'b00, 4'b0100, 8'hA5}); end
    i_transfer_done = 1'b1;
    cyc();
    i_transfer_done = 1'b0;
    checks++; if ({done, err, gnt, o_busy} !== {4'b0100, 4'b0, 4'b0, 1'b0}) begin errors++; $display("FAIL write_done: got %h expected %h", {done, err, gnt, o_busy}, {4'b0100, 4'b0, 4'b0, 1'b0}); end
    req = 4'b0010; req_chk = 4'b0010; req_data = 32'h0000_3C00; req_sel = 8'b00_00_01_00;
    cyc();
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0000", done); end
    checks++; if ({gnt, o_data, o_protocol_sel, o_data_ready, o_data_check} !== {4'b0010, 8'h3C, 2'b01, 2'b01}) begin errors++; $display("FAIL read_issue: got %h expected %h", {gnt, o_data, o_protocol_sel, o_data_ready, o_data_check}, {4'b0010, 8'h3C, 2'b01, 2'b01}); end
    req = 4'b0000; req_chk = 4'b0000;
    cyc();
    i_transfer_done = 1'b1;
    cyc();
    i_transfer_done = 1'b0;
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL read_done: got %b expected 0010", done); end
    cyc();
  endtask
  task automatic test_round_robin();
    logic [3:0] exp_g;
    PRESET = 1'b0; #2; PRESET = 1'b1;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      cyc();
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", n, gnt, exp_g); end
      cyc(); cyc();
      i_transfer_done = 1'b1;
      cyc();
      i_transfer_done = 1'b0;
      checks++; if ({done, gnt} !== {exp_g, 4'b0}) begin errors++; $display("FAIL rr_done%0d: got %b expected %b", n, {done, gnt}, {exp_g, 4'b0}); end
    end
    req = 4'b0000;
    cyc();
  endtask
  task automatic test_timeout();
    req = 4'b0001;
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL to_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      cyc();
      checks++; if ({gnt, err, o_busy} !== {4'b0001, 4'b0, 1'b1}) begin errors++; $display("FAIL to_wait%0d: got %b expected %b", i, {gnt, err, o_busy}, {4'b0001, 4'b0, 1'b1}); end
    end
    cyc();
    checks++; if ({err, done, gnt, o_busy} !== {4'b0001, 4'b0, 4'b0, 1'b0}) begin errors++; $display("FAIL to_err: got %b expected %b", {err, done, gnt, o_busy}, {4'b0001, 4'b0, 4'b0, 1'b0}); end
    cyc();
    checks++; if (err !== 4'b0) begin errors++; $display("FAIL to_err_pulse: got %b expected 0000", err); end
  endtask
  task automatic test_error_priority();
    req = 4'b0010;
    cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ep_gnt: got %b expected 0010", gnt); end
    req = 4'b0000;
    cyc();
    i_alu_error = 1'b1; i_transfer_done = 1'b1;
    cyc();
    i_transfer_done = 1'b0;
    checks++; if ({err, done, gnt} !== {4'b0010, 4'b0, 4'b0}) begin errors++; $display("FAIL ep_err: got %b expected %b", {err, done, gnt}, {4'b0010, 4'b0, 4'b0}); end
    req = 4'b0001;
    cyc(); cyc();
    checks++; if ({gnt, o_busy} !== 5'b0) begin errors++; $display("FAIL ep_idle_alu: got %b expected 00000", {gnt, o_busy}); end
    i_alu_error = 1'b0; i_waiting = 1'b0;
    cyc(); cyc();
    checks++; if ({gnt, o_busy} !== 5'b0) begin errors++; $display("FAIL ep_idle_nowait: got %b expected 00000", {gnt, o_busy}); end
    i_waiting = 1'b1;
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ep_resume: got %b expected 0001", gnt); end
    req = 4'b0000;
    cyc();
    i_transfer_done = 1'b1;
    cyc();
    i_transfer_done = 1'b0;
    cyc();
  endtask
  task automatic test_reset_mid();
    req = 4'b0100; req_data = 32'h0077_0000; req_sel = 8'b00_11_00_00;
    cyc();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rm_gnt: got %b expected 0100", gnt); end
    cyc(); cyc();
    PRESET = 1'b0;
    #1;
    checks++; if ({gnt, done, err, o_data, o_protocol_sel, o_data_ready, o_data_check, o_busy} !== 25'h0) begin errors++; $display("FAIL rm_async: got %h expected 0", {gnt, done, err, o_data, o_protocol_sel, o_data_ready, o_data_check, o_busy}); end
    i_transfer_done = 1'b1;
    cyc();
    i_transfer_done = 1'b0;
    checks++; if ({done, err} !== 8'h0) begin errors++; $display("FAIL rm_no_pulse: got %b expected 0", {done, err}); end
    PRESET = 1'b1; req = 4'b0101;
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_restart: got %b expected 0001", gnt); end
    req = 4'b0000;
    cyc();
    i_transfer_done = 1'b1;
    cyc();
    i_transfer_done = 1'b0;
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL rm_done: got %b expected 0001", done); end
  endtask
  initial begin
    test_reset();
    test_issue();
    test_round_robin();
    test_timeout();
    test_error_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
